// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI transmit framing path.
// Optional build macro used by this path: SPI_TX_UNDERRUN_ABORT_EN.
package spi_pkg;

    localparam int unsigned SPI_DW    = 8;
    localparam int unsigned SPI_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_tx_framer_if.sv
// Byte-write, frame-control and shifter handshake signals of spi_tx_framer.
// SPI_TX_UNDERRUN_ABORT_EN adds the underrun pulse.
interface spi_tx_framer_if
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = SPI_DW,
    parameter int unsigned LEN_W = SPI_LEN_W
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [DW-1:0]    wr_data;
    logic             wr_en;
    logic             full;
    logic [LW-1:0]    level;
    logic [LEN_W-1:0] frame_len;
    logic             start;
    logic             busy;
    logic [DW-1:0]    tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             cs_n;
    logic             frame_done;
`ifdef SPI_TX_UNDERRUN_ABORT_EN
    logic             underrun;
`endif

    // master: byte writer plus shift core; slave: the framer
    modport master (
`ifdef SPI_TX_UNDERRUN_ABORT_EN
        input  underrun,
`endif
        output wr_data, wr_en, frame_len, start, tx_ready,
        input  full, level, busy, tx_data, tx_valid, cs_n, frame_done
    );

    modport slave (
`ifdef SPI_TX_UNDERRUN_ABORT_EN
        output underrun,
`endif
        input  wr_data, wr_en, frame_len, start, tx_ready,
        output full, level, busy, tx_data, tx_valid, cs_n, frame_done
    );

endinterface

// File: rtl/spi_byte_fifo.sv
// Circular byte FIFO with a separate occupancy counter and zero-latency head read.
module spi_byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              wr_data,
    input  logic                       push,
    input  logic                       pop,
    output logic [DW-1:0]              rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // a full FIFO still accepts a write when the head leaves on the same edge
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_framer.sv
// Chip-select framing FSM feeding FIFO bytes to the SPI shifter.
// Define SPI_TX_UNDERRUN_ABORT_EN to abort a frame when the FIFO runs dry.
module spi_tx_framer
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = SPI_DW,
    parameter int unsigned LEN_W = SPI_LEN_W
) (
    input  logic            clk,
    input  logic            rst,
    spi_tx_framer_if.slave  bus
);
    localparam int unsigned RW = LEN_W + 1;

    state_t        state;
    logic [RW-1:0] remaining;
    logic          cs_q;
    logic          busy_q;
    logic          done_q;
    logic          empty;
    logic          tx_valid;
    logic          hs;

    assign tx_valid = (state == XFER) && !empty;
    assign hs       = tx_valid && bus.tx_ready;

    spi_byte_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (bus.wr_data),
        .push    (bus.wr_en),
        .pop     (hs),
        .rd_data (bus.tx_data),
        .full    (bus.full),
        .empty   (empty),
        .level   (bus.level)
    );

    assign bus.tx_valid   = tx_valid;
    assign bus.cs_n       = cs_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

`ifdef SPI_TX_UNDERRUN_ABORT_EN
    logic aborted;
    logic underrun_q;
    assign bus.underrun = underrun_q;
`endif

    // cs_n and busy are loaded on the transition edge so they track the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPI_TX_UNDERRUN_ABORT_EN
            aborted    <= 1'b0;
            underrun_q <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
`ifdef SPI_TX_UNDERRUN_ABORT_EN
            underrun_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        remaining <= (bus.frame_len == '0) ? (RW'(1) << LEN_W)
                                                           : RW'(bus.frame_len);
                        state     <= SETUP;
                        cs_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SETUP: state <= XFER;
                XFER: begin
                    if (hs) begin
                        remaining <= remaining - RW'(1);
                        if (remaining == RW'(1)) begin
                            state <= HOLD;
                        end
`ifdef SPI_TX_UNDERRUN_ABORT_EN
                    end else if (empty) begin
                        state   <= HOLD;
                        aborted <= 1'b1;
`endif
                    end
                end
                HOLD: begin
                    state  <= IDLE;
                    cs_q   <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
`ifdef SPI_TX_UNDERRUN_ABORT_EN
                    underrun_q <= aborted;
                    aborted    <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_framer.sv
// Scoreboard bench for spi_tx_framer: byte order, frame sizes and cs_n windows.
module tb_spi_tx_framer;
    import spi_pkg::*;

    typedef struct {
        int hs;
        int low;
        bit abort;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] exp_q[$];
    frame_t     frame_q[$];
    int         hs_cnt  = 0;
    int         low_cnt = 0;

    spi_tx_framer_if #(.DEPTH(4), .DW(8), .LEN_W(4)) bus ();

    spi_tx_framer #(.DEPTH(4), .DW(8), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit accepted);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        if (accepted) exp_q.push_back(d);
    endtask

    task automatic start_frame(input logic [3:0] len, input int hs, input int low, input bit abort);
        frame_t f;
        f.hs = hs; f.low = low; f.abort = abort;
        frame_q.push_back(f);
        bus.frame_len = len;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 200), 32'd1);
    endtask

    // monitor: compares every handshake and every frame end against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cs_n == 1'b0) low_cnt++;
            check("valid_cs", 32'(bus.tx_valid && bus.cs_n), 32'd0);
            if (bus.tx_valid && bus.tx_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) check("extra_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
                else check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
            if (bus.frame_done) begin
                check("cs_at_done", 32'(bus.cs_n), 32'd1);
                if (frame_q.size() == 0) begin
                    check("extra_frame", 32'd1, 32'd0 + 32'(frame_q.size()));
                end else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    check("frame_hs", 32'(hs_cnt), 32'(f.hs));
                    if (f.low != 0) check("cs_low_window", 32'(low_cnt), 32'(f.low));
`ifdef SPI_TX_UNDERRUN_ABORT_EN
                    check("underrun", 32'(bus.underrun), 32'(f.abort));
`endif
                end
                hs_cnt  = 0;
                low_cnt = 0;
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.wr_data   = '0;
        bus.wr_en     = 1'b0;
        bus.frame_len = '0;
        bus.start     = 1'b0;
        bus.tx_ready  = 1'b0;
        tick();
        tick();
        check("rst_cs_n", 32'(bus.cs_n), 32'd1);
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.frame_done), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("idle_cs_n", 32'(bus.cs_n), 32'd1);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_level", 32'(bus.level), 32'd0);
        end

        // start with an empty FIFO
`ifdef SPI_TX_UNDERRUN_ABORT_EN
        start_frame(4'd1, 0, 3, 1'b1);
`else
        start_frame(4'd1, 1, 0, 1'b0);
`endif
        check("setup_cs_n", 32'(bus.cs_n), 32'd0);
        check("setup_valid", 32'(bus.tx_valid), 32'd0);
        check("setup_busy", 32'(bus.busy), 32'd1);
        tick();
        check("stall_cs_n", 32'(bus.cs_n), 32'd0);
        check("stall_valid", 32'(bus.tx_valid), 32'd0);
`ifndef SPI_TX_UNDERRUN_ABORT_EN
        repeat (3) tick();
        check("stall_hold_cs_n", 32'(bus.cs_n), 32'd0);
        bus.tx_ready = 1'b1;
        push_byte(8'h33, 1'b1);
`endif
        wait_idle();
        bus.tx_ready = 1'b1;

        // basic frame; start during XFER must be ignored
        push_byte(8'hAA, 1'b1);
        push_byte(8'h55, 1'b1);
        push_byte(8'hCC, 1'b1);
        check("basic_level", 32'(bus.level), 32'd3);
        start_frame(4'd3, 3, 5, 1'b0);
        check("basic_setup_valid", 32'(bus.tx_valid), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("basic_first_valid", 32'(bus.tx_valid), 32'd1);
        check("basic_first_data", 32'(bus.tx_data), 32'hAA);
        wait_idle();

        // backpressure
        push_byte(8'hAA, 1'b1);
        push_byte(8'h55, 1'b1);
        push_byte(8'hCC, 1'b1);
        start_frame(4'd3, 3, 7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.tx_ready = (i % 2 == 0);
            tick();
        end
        bus.tx_ready = 1'b1;
        wait_idle();

        // overflow, then push while full with a pop in the same cycle
        for (int i = 1; i <= 5; i++) push_byte(8'(i), i <= 4);
        check("ovf_full", 32'(bus.full), 32'd1);
        check("ovf_level", 32'(bus.level), 32'd4);
        start_frame(4'd4, 4, 6, 1'b0);
        tick();
        push_byte(8'h10, 1'b1);
        check("pushpop_level", 32'(bus.level), 32'd4);
        check("pushpop_full", 32'(bus.full), 32'd1);
        wait_idle();
        check("wrap_level", 32'(bus.level), 32'd1);
        start_frame(4'd1, 1, 3, 1'b0);
        wait_idle();

        // frame_len 0 -> 16 bytes, refilled while streaming
        for (int i = 0; i < 4; i++) push_byte(8'h80 + 8'(i), 1'b1);
        start_frame(4'd0, 16, 18, 1'b0);
        tick();
        for (int i = 4; i < 16; i++) push_byte(8'h80 + 8'(i), 1'b1);
        wait_idle();
        check("len0_level", 32'(bus.level), 32'd0);

        // underrun: 3-byte frame with only 2 bytes queued
        push_byte(8'h41, 1'b1);
        push_byte(8'h42, 1'b1);
`ifdef SPI_TX_UNDERRUN_ABORT_EN
        start_frame(4'd3, 2, 5, 1'b1);
`else
        start_frame(4'd3, 3, 0, 1'b0);
        repeat (6) tick();
        check("underrun_wait_busy", 32'(bus.busy), 32'd1);
        check("underrun_wait_cs", 32'(bus.cs_n), 32'd0);
        push_byte(8'h33, 1'b1);
`endif
        wait_idle();

        // back-to-back: start in the frame_done cycle is accepted
        push_byte(8'h61, 1'b1);
        push_byte(8'h62, 1'b1);
        start_frame(4'd1, 1, 3, 1'b0);
        wait_idle();
        check("b2b_done", 32'(bus.frame_done), 32'd1);
        check("b2b_gap_cs", 32'(bus.cs_n), 32'd1);
        start_frame(4'd1, 1, 3, 1'b0);
        check("b2b_cs_low", 32'(bus.cs_n), 32'd0);
        wait_idle();
        tick();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("frames_drained", 32'(frame_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
